// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-requester SDRAM arbiter.
//   arb_state_t : FSM encoding (IDLE, ISSUE, BUSY)
//   grant_t     : owner index (0 = video/m0, 1 = CPU/m1)
package sdram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  typedef logic grant_t;

  localparam grant_t GRANT_M0 = 1'b0;
  localparam grant_t GRANT_M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// BUSY-phase watchdog: saturating cycle counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : force count to zero (held while not in BUSY)
//   enable_i      : count one cycle
//   expired_o     : count has reached ACK_TIMEOUT
module sdram_arb_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = (count_q == CNT_W'(ACK_TIMEOUT));

  // Saturate at ACK_TIMEOUT so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM arbiter: m0 (video) and m1 (CPU) share one SDRAM port.
// One transaction at a time: IDLE -> ISSUE (command handshake) -> BUSY
// (responses until the owner acks or the watchdog fires) -> IDLE.
//   clk_i, rst_ni          : clock, async active-low reset
//   m0_* / m1_*            : requester command, response and release ports
//   rdata_o                : shared read data, qualified by mN_resp_valid
//   sdram_*                : controller-side command/response/release
//   grant_o, busy_o        : current owner, not-IDLE
//   timeout_err_o          : sticky watchdog expiry flag
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin arbitration on
// simultaneous requests instead of fixed m0 priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr_x16,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_resp_valid,
  input  logic              m0_ack,

  input  logic              m1_cmd_valid,
  output logic              m1_cmd_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr_x16,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_resp_valid,
  input  logic              m1_ack,

  output logic [DATA_W-1:0] rdata_o,

  output logic              sdram_cmd_valid,
  input  logic              sdram_cmd_ready,
  output logic              sdram_we,
  output logic [ADDR_W-1:0] sdram_addr_x16,
  output logic [DATA_W-1:0] sdram_wdata,
  input  logic              sdram_resp_valid,
  input  logic [DATA_W-1:0] sdram_rdata,
  output logic              sdram_ack,

  output logic              grant_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  arb_state_t state_q, state_d;
  grant_t     grant_q, grant_d;
  logic       timeout_err_q, timeout_err_d;
  grant_t     winner;
  logic       gnt_ack;
  logic       wd_expired;
  logic       in_issue, in_busy;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  grant_t     last_grant_q, last_grant_d;

  // Contended: hand over to whoever was not served last.
  always_comb begin
    winner = m0_cmd_valid ? GRANT_M0 : GRANT_M1;
    if (m0_cmd_valid && m1_cmd_valid) begin
      winner = ~last_grant_q;
    end
  end
`else
  // Fixed priority: video always wins when it asks.
  always_comb begin
    winner = m0_cmd_valid ? GRANT_M0 : GRANT_M1;
  end
`endif

  assign in_issue = (state_q == ISSUE);
  assign in_busy  = (state_q == BUSY);
  assign gnt_ack  = (grant_q == GRANT_M1) ? m1_ack : m0_ack;

  sdram_arb_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (!in_busy),
    .enable_i  (in_busy),
    .expired_o (wd_expired)
  );

  // Next-state logic; sdram_ack is the only FSM-driven output.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    timeout_err_d = timeout_err_q;
    sdram_ack     = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_cmd_valid || m1_cmd_valid) begin
          grant_d = winner;
          state_d = ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      ISSUE: begin
        if (sdram_cmd_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (gnt_ack) begin
          sdram_ack = 1'b1;
          state_d   = IDLE;
        end else if (wd_expired) begin
          sdram_ack     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_M0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Resets to m1 so that m0 wins the first contended arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= GRANT_M1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Command path: muxed from the owner, zero latency.
  assign sdram_cmd_valid = in_issue;
  assign sdram_we        = (grant_q == GRANT_M1) ? m1_we       : m0_we;
  assign sdram_addr_x16  = (grant_q == GRANT_M1) ? m1_addr_x16 : m0_addr_x16;
  assign sdram_wdata     = (grant_q == GRANT_M1) ? m1_wdata    : m0_wdata;
  assign m0_cmd_ready    = in_issue && (grant_q == GRANT_M0) && sdram_cmd_ready;
  assign m1_cmd_ready    = in_issue && (grant_q == GRANT_M1) && sdram_cmd_ready;

  // Response path: stray responses outside BUSY are dropped.
  assign m0_resp_valid   = in_busy && (grant_q == GRANT_M0) && sdram_resp_valid;
  assign m1_resp_valid   = in_busy && (grant_q == GRANT_M1) && sdram_resp_valid;
  assign rdata_o         = sdram_rdata;

  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE);
  assign timeout_err_o   = timeout_err_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 24, word address width in 16-bit words; DATA_W, default 16, data width; ACK_TIMEOUT, default 1023, maximum cycles in BUSY before forced release.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed in REQ-003 to REQ-008.
REQ-003 Clock and reset ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 Requester 0 (video, high priority) ports:
  m0_cmd_valid  in  1  request;
  m0_cmd_ready  out  1  command accepted;
  m0_we  in  1  1=write;
  m0_addr_x16  in  ADDR_W  word address;
  m0_wdata  in  DATA_W  write data;
  m0_resp_valid  out  1  read word valid;
  m0_ack  in  1  transaction done, release.
REQ-005 Requester 1 (CPU) ports: m1_cmd_valid, m1_cmd_ready, m1_we, m1_addr_x16, m1_wdata, m1_resp_valid and m1_ack SHALL be identical to REQ-004.
REQ-006 Shared read data: rdata_o  out  DATA_W  read data, meaningful only with mN_resp_valid.
REQ-007 SDRAM-side ports:
  sdram_cmd_valid  out  1;
  sdram_cmd_ready  in  1;
  sdram_we  out  1;
  sdram_addr_x16  out  ADDR_W;
  sdram_wdata  out  DATA_W;
  sdram_resp_valid  in  1;
  sdram_rdata  in  DATA_W;
  sdram_ack  out  1.
REQ-008 Status ports: grant_o  out  1  current owner (0/1); busy_o  out  1  state!=IDLE; timeout_err_o  out  1  sticky watchdog error.

Function
REQ-009 The FSM SHALL have three states: IDLE, ISSUE and BUSY.
REQ-010 IDLE: if any mN_cmd_valid, the block SHALL register the winner into grant and move to ISSUE next cycle; if no valid, it SHALL stay in IDLE.
REQ-011 Arbitration (default): m0 SHALL win whenever m0_cmd_valid=1; m1 SHALL win only when m0_cmd_valid=0.
REQ-012 ISSUE: sdram_cmd_valid=1; sdram_we, sdram_addr_x16 and sdram_wdata SHALL be combinationally muxed from the granted requester.
REQ-013 The granted requester's mN_cmd_ready SHALL equal sdram_cmd_ready while in ISSUE; the non-granted requester's cmd_ready SHALL be 0 at all times.
REQ-014 In ISSUE, when sdram_cmd_valid&&sdram_cmd_ready, the FSM SHALL move to BUSY next cycle; requesters hold valid/we/addr/wdata stable until ready.
REQ-015 BUSY: sdram_resp_valid SHALL be routed combinationally (zero latency) to the granted mN_resp_valid only; rdata_o=sdram_rdata.
REQ-016 BUSY: the granted mN_ack SHALL pass through to sdram_ack in the same cycle, and the FSM SHALL return to IDLE next cycle.
REQ-017 A non-granted mN_ack SHALL be ignored.
REQ-018 An ack and a new valid in the same cycle: the new request SHALL be arbitrated in IDLE on the following cycle, giving a minimum 1-cycle gap between grants.
REQ-019 Watchdog: a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-020 When the watchdog counter reaches ACK_TIMEOUT, the block SHALL drive sdram_ack=1 for one cycle, set timeout_err_o (sticky until reset) and return to IDLE.
REQ-021 The counter width SHALL be $clog2(ACK_TIMEOUT+1) and the counter SHALL NOT wrap.
REQ-022 sdram_resp_valid in IDLE or ISSUE SHALL be dropped; no mN_resp_valid is asserted.

Reset
REQ-023 On rst_ni=0, asynchronously: state=IDLE, grant=0, counter=0, timeout_err_o=0, sdram_cmd_valid=0, sdram_ack=0, all mN_cmd_ready=0, all mN_resp_valid=0.
REQ-024 A reset mid-transaction SHALL abandon the transaction; no ack is issued.

Configuration
REQ-025 With SDRAM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: on simultaneous valid, the requester not granted last SHALL win; the last-grant flop resets to 1, so m0 wins first.
REQ-026 Without SDRAM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority per REQ-011, and no last-grant flop SHALL exist.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold: the arb_state_t enum (IDLE, ISSUE, BUSY), the grant_t typedef, and the ADDR_W/DATA_W defaults.
REQ-028 The watchdog counter SHALL be one sub-module, sdram_arb_watchdog, with inputs clear/enable and output expired.

Verification
REQ-029 m0 read, addr 0x800000; sdram_cmd_ready after 2 cycles; 64 resp words; m0_ack -> m0_cmd_ready high exactly 1 cycle, 64 m0_resp_valid, 0 m1_resp_valid, sdram_ack same cycle as m0_ack, IDLE next cycle.
REQ-030 m0 and m1 valid in the same cycle, fixed priority -> grant_o=0; m1_cmd_ready stays 0 until m0 acks; m1 issued 2 cycles after m0_ack.
REQ-031 Round-robin build, both valid continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-032 m1 write granted, no ack for 1023 BUSY cycles -> sdram_ack pulses once, timeout_err_o=1 stays set, next request is served.
REQ-033 rst_ni asserted in BUSY with 10 words delivered -> outputs zero immediately, no sdram_ack; after release an m0 request completes normally.
REQ-034 Stray sdram_resp_valid in IDLE, and m1_ack while m0 is granted -> no resp routed; m0 transaction unaffected.
